// File: rtl/quartz_arm_timer.sv
// quartz_arm_timer: NCH independent quarantine countdown channels with shared
// fail counting and a timed lockout on repeated arm attempts without a valid password.
module quartz_arm_timer #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned DURATION   = 60,
    parameter int unsigned MAX_FAIL   = 3,
    parameter int unsigned LOCK_TICKS = 30
) (
    input  logic                 SLOWCLOCK,
    input  logic                 RESET,
    input  logic [NCH-1:0]       PULSE,
    input  logic                 pass,
    input  logic [NCH-1:0]       ABORT,
    output logic [NCH-1:0]       QUARTZ,
    output logic [NCH*CNT_W-1:0] COUNT,
    output logic [NCH-1:0]       DONE,
    output logic [3:0]           FAIL_CNT,
    output logic                 LOCKED
);
    typedef enum logic [1:0] {IDLE, ACTIVE, EXPIRE} state_t;

    state_t           state    [NCH];
    state_t           state_nx [NCH];
    logic [CNT_W-1:0] cnt      [NCH];
    logic [CNT_W-1:0] cnt_nx   [NCH];
    logic [CNT_W-1:0] lock_cnt;
    logic [NCH-1:0]   idle;
    logic             attempt;

    always_ff @(posedge SLOWCLOCK) begin
        for (int i = 0; i < NCH; i++) begin
            state[i] <= RESET ? IDLE : state_nx[i];
            cnt[i]   <= RESET ? '0 : cnt_nx[i];
        end
    end

    // Priority per channel: abort, then expiry/countdown, then arm.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_nx[i] = state[i];
            cnt_nx[i]   = cnt[i];
            if (ABORT[i]) begin
                state_nx[i] = IDLE;
                cnt_nx[i]   = '0;
            end else if (state[i] == ACTIVE) begin
                if (cnt[i] == '0) state_nx[i] = EXPIRE;
                else cnt_nx[i] = cnt[i] - 1'b1;
            end else if (state[i] == EXPIRE) begin
                state_nx[i] = IDLE;
            end else if (PULSE[i] && pass && !LOCKED) begin
                state_nx[i] = ACTIVE;
                cnt_nx[i]   = CNT_W'(DURATION - 1);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign idle[g]                  = state[g] == IDLE;
        assign QUARTZ[g]                = state[g] == ACTIVE;
        assign DONE[g]                  = state[g] == EXPIRE;
        assign COUNT[g*CNT_W +: CNT_W]  = cnt[g];
    end

    // Simultaneous pulses on several idle channels are one attempt.
    assign attempt = !LOCKED && |(PULSE & idle & ~ABORT);

    always_ff @(posedge SLOWCLOCK) begin
        if (RESET) begin
            FAIL_CNT <= '0;
            LOCKED   <= 1'b0;
            lock_cnt <= '0;
        end else if (LOCKED) begin
            if (lock_cnt == '0) LOCKED <= 1'b0;
            else lock_cnt <= lock_cnt - 1'b1;
        end else if (attempt && pass) begin
            FAIL_CNT <= '0;
        end else if (attempt) begin
            if (FAIL_CNT + 4'd1 == 4'(MAX_FAIL)) begin
                FAIL_CNT <= '0;
                LOCKED   <= 1'b1;
                lock_cnt <= CNT_W'(LOCK_TICKS - 1);
            end else begin
                FAIL_CNT <= FAIL_CNT + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_quartz_arm_timer.sv
// tb_quartz_arm_timer: directed stimulus with a remaining-ticks model checked every cycle,
// plus hand-computed spot checks.
module tb_quartz_arm_timer;
    localparam int NCH = 4, CNT_W = 8, DURATION = 5, MAX_FAIL = 3, LOCK_TICKS = 4;

    logic                 SLOWCLOCK = 1'b0;
    logic                 RESET = 1'b1;
    logic [NCH-1:0]       PULSE = '0;
    logic                 pass = 1'b0;
    logic [NCH-1:0]       ABORT = '0;
    logic [NCH-1:0]       QUARTZ;
    logic [NCH*CNT_W-1:0] COUNT;
    logic [NCH-1:0]       DONE;
    logic [3:0]           FAIL_CNT;
    logic                 LOCKED;

    int tests = 0, fails = 0;

    quartz_arm_timer #(.NCH(NCH), .CNT_W(CNT_W), .DURATION(DURATION),
                       .MAX_FAIL(MAX_FAIL), .LOCK_TICKS(LOCK_TICKS)) dut (
        .SLOWCLOCK(SLOWCLOCK), .RESET(RESET), .PULSE(PULSE), .pass(pass), .ABORT(ABORT),
        .QUARTZ(QUARTZ), .COUNT(COUNT), .DONE(DONE), .FAIL_CNT(FAIL_CNT), .LOCKED(LOCKED)
    );

    always #5 SLOWCLOCK = ~SLOWCLOCK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_left = edges QUARTZ still has to stay high; m_lock = lockout edges remaining.
    int m_left [NCH];
    bit m_done [NCH];
    int m_fail = 0, m_lock = 0;

    always @(posedge SLOWCLOCK) begin
        logic [NCH-1:0]       eq, ed;
        logic [NCH*CNT_W-1:0] ec;
        bit att;
        if (RESET) begin
            for (int i = 0; i < NCH; i++) begin m_left[i] = 0; m_done[i] = 0; end
            m_fail = 0;
            m_lock = 0;
        end else begin
            att = 0;
            for (int i = 0; i < NCH; i++)
                if (PULSE[i] && !ABORT[i] && m_left[i] == 0 && !m_done[i] && m_lock == 0) att = 1;
            for (int i = 0; i < NCH; i++) begin
                if (ABORT[i]) begin m_left[i] = 0; m_done[i] = 0; end
                else if (m_left[i] > 0) begin m_left[i]--; m_done[i] = (m_left[i] == 0); end
                else if (m_done[i]) m_done[i] = 0;
                else if (PULSE[i] && pass && m_lock == 0) m_left[i] = DURATION;
            end
            if (m_lock > 0) m_lock--;
            else if (att && pass) m_fail = 0;
            else if (att) begin
                m_fail++;
                if (m_fail == MAX_FAIL) begin m_fail = 0; m_lock = LOCK_TICKS; end
            end
        end
        #1;
        for (int i = 0; i < NCH; i++) begin
            eq[i] = m_left[i] > 0;
            ed[i] = m_done[i];
            ec[i*CNT_W +: CNT_W] = m_left[i] > 0 ? CNT_W'(m_left[i] - 1) : '0;
        end
        chk("model QUARTZ", 64'(QUARTZ), 64'(eq));
        chk("model COUNT", 64'(COUNT), 64'(ec));
        chk("model DONE", 64'(DONE), 64'(ed));
        chk("model FAIL_CNT", 64'(FAIL_CNT), 64'(m_fail));
        chk("model LOCKED", 64'(LOCKED), 64'(m_lock > 0));
    end

    task automatic cyc(input logic [NCH-1:0] p, input logic ps, input logic [NCH-1:0] a);
        PULSE = p;
        pass  = ps;
        ABORT = a;
        @(negedge SLOWCLOCK);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc('0, 1'b0, '0);
    endtask

    initial begin
        @(negedge SLOWCLOCK);
        idle(2);
        chk("reset QUARTZ", 64'(QUARTZ), 0);
        chk("reset COUNT", 64'(COUNT), 0);
        chk("reset FAIL_CNT", 64'(FAIL_CNT), 0);
        chk("reset LOCKED", 64'(LOCKED), 0);
        RESET = 1'b0;
        // T1 basic countdown
        cyc(4'b0001, 1'b1, '0);
        chk("t1 QUARTZ arm", 64'(QUARTZ), 64'h1);
        chk("t1 COUNT0 first", 64'(COUNT[7:0]), 4);
        idle(4);
        chk("t1 COUNT0 last", 64'(COUNT[7:0]), 0);
        chk("t1 QUARTZ last", 64'(QUARTZ), 64'h1);
        idle(1);
        chk("t1 DONE pulse", 64'(DONE), 64'h1);
        chk("t1 QUARTZ fall", 64'(QUARTZ), 0);
        idle(1);
        chk("t1 DONE clear", 64'(DONE), 0);
        // T2 sticky re-pulse and pulse during expiry
        cyc(4'b0001, 1'b1, '0);
        idle(2);
        chk("t2 COUNT0 at 2", 64'(COUNT[7:0]), 2);
        cyc(4'b0001, 1'b0, '0);
        chk("t2 COUNT0 ignored", 64'(COUNT[7:0]), 1);
        chk("t2 FAIL unchanged", 64'(FAIL_CNT), 0);
        idle(2);
        chk("t2 DONE on time", 64'(DONE), 64'h1);
        cyc(4'b0001, 1'b0, '0);
        chk("t2 expire pulse QUARTZ", 64'(QUARTZ), 0);
        chk("t2 expire pulse FAIL", 64'(FAIL_CNT), 0);
        // T3 lockout
        cyc(4'b0010, 1'b0, '0);
        chk("t3 FAIL 1", 64'(FAIL_CNT), 1);
        cyc(4'b0010, 1'b0, '0);
        chk("t3 FAIL 2", 64'(FAIL_CNT), 2);
        cyc(4'b0010, 1'b0, '0);
        chk("t3 LOCKED set", 64'(LOCKED), 1);
        chk("t3 FAIL cleared", 64'(FAIL_CNT), 0);
        cyc(4'b0010, 1'b1, '0);
        chk("t3 no arm locked", 64'(QUARTZ), 0);
        idle(2);
        chk("t3 still LOCKED", 64'(LOCKED), 1);
        idle(1);
        chk("t3 unlocked", 64'(LOCKED), 0);
        cyc(4'b0010, 1'b1, '0);
        chk("t3 arm after lock", 64'(QUARTZ), 64'h2);
        chk("t3 COUNT1", 64'(COUNT[15:8]), 4);
        idle(6);
        // T4 success clears fails, multi-pulse counts once
        cyc(4'b0100, 1'b0, '0);
        cyc(4'b0100, 1'b0, '0);
        chk("t4 FAIL 2", 64'(FAIL_CNT), 2);
        cyc(4'b0100, 1'b1, '0);
        chk("t4 FAIL reset", 64'(FAIL_CNT), 0);
        cyc(4'b1111, 1'b0, '0);
        chk("t4 multi one fail", 64'(FAIL_CNT), 1);
        // T5 abort
        chk("t5 COUNT2 at 3", 64'(COUNT[23:16]), 3);
        cyc('0, 1'b1, 4'b0100);
        chk("t5 abort QUARTZ", 64'(QUARTZ), 0);
        chk("t5 abort COUNT2", 64'(COUNT[23:16]), 0);
        cyc(4'b1000, 1'b1, 4'b1000);
        chk("t5 abort idle no arm", 64'(QUARTZ), 0);
        chk("t5 abort no attempt", 64'(FAIL_CNT), 1);
        chk("t5 no DONE", 64'(DONE), 0);
        // abort beats expiry
        cyc(4'b0001, 1'b1, '0);
        idle(4);
        cyc('0, 1'b0, 4'b0001);
        chk("t5 abort at expiry DONE", 64'(DONE), 0);
        // T6 reset mid-countdown and mid-lockout
        cyc(4'b0010, 1'b1, '0);
        cyc(4'b0001, 1'b0, '0);
        cyc(4'b0001, 1'b0, '0);
        cyc(4'b0001, 1'b0, '0);
        chk("t6 LOCKED", 64'(LOCKED), 1);
        chk("t6 QUARTZ1 active", 64'(QUARTZ), 64'h2);
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        chk("t6 reset QUARTZ", 64'(QUARTZ), 0);
        chk("t6 reset COUNT", 64'(COUNT), 0);
        chk("t6 reset LOCKED", 64'(LOCKED), 0);
        idle(1);
        chk("t6 no DONE", 64'(DONE), 0);
        cyc(4'b0010, 1'b1, '0);
        chk("t6 arm after reset", 64'(QUARTZ), 64'h2);
        idle(7);
        // all channels together
        cyc(4'b1111, 1'b1, '0);
        chk("all arm", 64'(QUARTZ), 64'hf);
        idle(5);
        chk("all DONE", 64'(DONE), 64'hf);
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
